// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: request/ready bus between the MEM-stage access
// controller and a multi-cycle data memory.
//   bus_req   master->slave  request, held until bus_ready
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned byte address
//   bus_be    master->slave  byte enables, little-endian lanes
//   bus_wdata master->slave  store data replicated onto the selected lanes
//   bus_ready slave->master  access completes this cycle
//   bus_rdata slave->master  read word, valid with bus_ready
interface mem_access_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access controller.
// Takes the registered EX/MEM memory controls, issues one request on the
// data bus, stalls the pipeline until the memory answers (or a timeout
// expires), then presents aligned, extended load data to MEM/WB.
//
// Parameters:
//   TIMEOUT  max cycles in REQ without bus_ready before aborting (>= 2)
// Optional feature:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses skip the
//                         bus and retire immediately with bus_err
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_read, mem_write   memory op in MEM stage (write wins if both)
//   bhw                   size: 00 word, 01 half, 10 byte, 11 word
//   ext_sign              1 = sign-extend sub-word loads
//   addr, store_data      ALU byte address, store value
//   bus                   data-memory bus (master side)
//   stall                 holds IF/ID/EX and EX/MEM
//   load_data             aligned/extended load result, held until next load
//   done                  one-cycle pulse when the access retires
//   bus_err               one-cycle pulse on timeout / trapped misalignment
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [1:0]                 bhw,
    input  logic                       ext_sign,
    input  logic [31:0]                addr,
    input  logic [31:0]                store_data,
    mem_access_stage_if.master         bus,
    output logic                       stall,
    output logic [31:0]                load_data,
    output logic                       done,
    output logic                       bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e        stateQ, stateD;
    logic [CntW-1:0] cntQ;
    logic          weQ;
    logic [31:0]   addrQ;
    logic [3:0]    beQ;
    logic [31:0]   wdataQ;
    logic [1:0]    bhwQ;
    logic          signQ;
    logic [1:0]    lowQ;
    logic          errQ;
    logic [31:0]   loadQ;

    logic          opReq;
    logic          isHalf, isByte;
    logic [3:0]    beD;
    logic [31:0]   wdataD;
    logic          misaligned;
    logic [31:0]   extracted;

    assign opReq  = mem_read | mem_write;
    assign isHalf = (bhw == 2'b01);
    assign isByte = (bhw == 2'b10);

    // Lane decode from the live EX/MEM inputs; latched on IDLE -> REQ.
    always_comb begin
        beD    = 4'b1111;
        wdataD = store_data;
        if (isHalf) begin
            beD    = addr[1] ? 4'b1100 : 4'b0011;
            wdataD = {2{store_data[15:0]}};
        end else if (isByte) begin
            beD    = 4'b0001 << addr[1:0];
            wdataD = {4{store_data[7:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (isHalf & addr[0]) | (~isHalf & ~isByte & (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Extract from the read word using the size/offset latched at issue.
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byteVal;
        half    = lowQ[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        byteVal = bus.bus_rdata[7:0];
        case (lowQ)
            2'd0:    byteVal = bus.bus_rdata[7:0];
            2'd1:    byteVal = bus.bus_rdata[15:8];
            2'd2:    byteVal = bus.bus_rdata[23:16];
            default: byteVal = bus.bus_rdata[31:24];
        endcase
        case (bhwQ)
            2'b01:   extracted = {{16{signQ & half[15]}}, half};
            2'b10:   extracted = {{24{signQ & byteVal[7]}}, byteVal};
            default: extracted = bus.bus_rdata;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: if (opReq) stateD = misaligned ? StDone : StReq;
            StReq:  if (bus.bus_ready || (cntQ == CntMax)) stateD = StDone;
            StDone: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            beQ    <= '0;
            wdataQ <= '0;
            bhwQ   <= '0;
            signQ  <= 1'b0;
            lowQ   <= '0;
            errQ   <= 1'b0;
            loadQ  <= '0;
        end else begin
            stateQ <= stateD;
            unique case (stateQ)
                StIdle: begin
                    if (opReq) begin
                        errQ <= misaligned;
                        cntQ <= '0;
                        // A trapped access never reaches the bus, so keep the bus state.
                        if (!misaligned) begin
                            weQ    <= mem_write;
                            addrQ  <= {addr[31:2], 2'b00};
                            beQ    <= beD;
                            wdataQ <= wdataD;
                            bhwQ   <= bhw;
                            signQ  <= ext_sign;
                            lowQ   <= addr[1:0];
                        end
                    end
                end
                StReq: begin
                    if (bus.bus_ready) begin
                        errQ <= 1'b0;
                        if (!weQ) loadQ <= extracted;
                    end else if (cntQ == CntMax) begin
                        errQ  <= 1'b1;
                        loadQ <= '0;
                    end else begin
                        cntQ <= cntQ + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = (stateQ == StReq);
    assign bus.bus_we    = weQ;
    assign bus.bus_addr  = addrQ;
    assign bus.bus_be    = beQ;
    assign bus.bus_wdata = wdataQ;

    // The IDLE term is combinational so the op is frozen from its first cycle.
    assign stall     = ((stateQ == StIdle) & opReq) | (stateQ == StReq);
    assign done      = (stateQ == StDone);
    assign bus_err   = (stateQ == StDone) & errQ;
    assign load_data = loadQ;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage.
// Each issued op pushes its hand-computed response; a negedge monitor pops
// it on done and compares load data, error, bus fields and cycle counts.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, ext_sign;
    logic [1:0]  bhw;
    logic [31:0] addr, store_data;
    logic        stall, done, bus_err;
    logic [31:0] load_data;

    mem_access_stage_if busIf ();

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .bhw        (bhw),
        .ext_sign   (ext_sign),
        .addr       (addr),
        .store_data (store_data),
        .bus        (busIf),
        .stall      (stall),
        .load_data  (load_data),
        .done       (done),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] ld;
        logic        err;
        int          req;
        int          stl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    int          rcnt = 0;
    int          scnt = 0;
    logic        capt = 1'b0;
    logic [31:0] cAddr, cWdata;
    logic [3:0]  cBe;
    logic        cWe;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            rcnt = 0;
            scnt = 0;
            capt = 1'b0;
        end else begin
            if (stall) scnt++;
            if (busIf.bus_req) begin
                rcnt++;
                if (!capt) begin
                    cAddr  = busIf.bus_addr;
                    cWdata = busIf.bus_wdata;
                    cBe    = busIf.bus_be;
                    cWe    = busIf.bus_we;
                    capt   = 1'b1;
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no retire");
                end else begin
                    e = sbq.pop_front();
                    chk("load_data", load_data, e.ld);
                    chk("bus_err", {31'b0, bus_err}, {31'b0, e.err});
                    chk("req_cycles", rcnt, e.req);
                    chk("stall_cycles", scnt, e.stl);
                    if (e.req > 0) begin
                        chk("bus_addr", cAddr, e.addr);
                        chk("bus_be", {28'b0, cBe}, {28'b0, e.be});
                        chk("bus_wdata", cWdata, e.wdata);
                        chk("bus_we", {31'b0, cWe}, {31'b0, e.we});
                    end
                end
                rcnt = 0;
                scnt = 0;
                capt = 1'b0;
            end
        end
    end

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 of the next IDLE cycle.
    task automatic runOp(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         input int dly, input exp_t ex);
        int n;
        int rc;
        bit got;
        n   = 0;
        rc  = 0;
        got = 0;
        sbq.push_back(ex);
        mem_read   = rd;
        mem_write  = wr;
        bhw        = sz;
        ext_sign   = sg;
        addr       = a;
        store_data = sd;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                got       = 1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                busIf.bus_ready = 1'b0;
            end else if (busIf.bus_req) begin
                busIf.bus_ready = (dly >= 0) && (rc == dly);
                busIf.bus_rdata = rdat;
                rc++;
            end else begin
                busIf.bus_ready = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL retire_%h: got no done in 40 cycles expected done", a);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            busIf.bus_ready = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_bus_req"}, {31'b0, busIf.bus_req}, 32'h0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
        chk({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
        chk({tag, "_bus_we"}, {31'b0, busIf.bus_we}, 32'h0);
        chk({tag, "_bus_addr"}, busIf.bus_addr, 32'h0);
        chk({tag, "_bus_be"}, {28'b0, busIf.bus_be}, 32'h0);
        chk({tag, "_bus_wdata"}, busIf.bus_wdata, 32'h0);
        chk({tag, "_load_data"}, load_data, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        bhw = 2'b00;
        ext_sign = 1'b0;
        addr = '0;
        store_data = '0;
        busIf.bus_ready = 1'b0;
        busIf.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chkReset("reset");
        rst = 1'b0;

        // addr, be, wdata, we, load_data, err, req cycles, stall cycles
        runOp(1, 0, 2'b00, 0, 32'h104, 32'h0, 32'hDEADBEEF, 0,
              '{32'h104, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 2});
        runOp(1, 0, 2'b10, 1, 32'h203, 32'h0, 32'h80112233, 0,
              '{32'h200, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1, 2});
        runOp(1, 0, 2'b10, 0, 32'h203, 32'h0, 32'h80112233, 0,
              '{32'h200, 4'b1000, 32'h0, 1'b0, 32'h00000080, 1'b0, 1, 2});
        runOp(0, 1, 2'b01, 0, 32'h32, 32'h0000ABCD, 32'h0, 3,
              '{32'h30, 4'b1100, 32'hABCDABCD, 1'b1, 32'h00000080, 1'b0, 4, 5});
        runOp(1, 0, 2'b00, 0, 32'h400, 32'h0, 32'h11111111, -1,
              '{32'h400, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, 16, 17});
        runOp(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h87654321, 0,
              '{32'h10, 4'b1100, 32'h0, 1'b0, 32'hFFFF8765, 1'b0, 1, 2});
        runOp(1, 0, 2'b01, 0, 32'h20, 32'h0, 32'h1234F00D, 0,
              '{32'h20, 4'b0011, 32'h0, 1'b0, 32'h0000F00D, 1'b0, 1, 2});
        // Read and write together: the write wins, load_data untouched.
        runOp(1, 1, 2'b10, 0, 32'h1, 32'h0000005A, 32'hFFFFFFFF, 1,
              '{32'h0, 4'b0010, 32'h5A5A5A5A, 1'b1, 32'h0000F00D, 1'b0, 2, 3});
        runOp(0, 1, 2'b11, 0, 32'h8, 32'h13579BDF, 32'h0, 0,
              '{32'h8, 4'b1111, 32'h13579BDF, 1'b1, 32'h0000F00D, 1'b0, 1, 2});

        // Reset during the second REQ cycle.
        mem_read = 1'b1;
        bhw = 2'b00;
        addr = 32'h500;
        store_data = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_pre_bus_req", {31'b0, busIf.bus_req}, 32'h1);
        rst = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chkReset("midrst");

        runOp(1, 0, 2'b00, 0, 32'h504, 32'h0, 32'h12345678, 1,
              '{32'h504, 4'b1111, 32'h0, 1'b0, 32'h12345678, 1'b0, 2, 3});
`ifdef MEM_MISALIGN_TRAP_EN
        runOp(1, 0, 2'b00, 0, 32'h102, 32'h0, 32'hCAFEF00D, 0,
              '{32'h0, 4'b0000, 32'h0, 1'b0, 32'h12345678, 1'b1, 0, 1});
`else
        runOp(1, 0, 2'b00, 0, 32'h102, 32'h0, 32'hCAFEF00D, 0,
              '{32'h100, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1, 2});
`endif

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending: got %0d unretired ops expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
